stack_data_mem: RTL and testbench
=================================

Name: stack_data_mem

Overview:
- Parametrised byte-addressed little-endian data memory with a bounds-checked hardware stack.
- Next generation of the core's memory/stack stage: adds sized loads/stores, RET, valid/ready request handshake, a registered response, and fault detection with a sticky FAULT state.
- Sits in the MEM stage; the control unit issues one decoded operation per request.

Parameters:
ADDR_W, 10, byte-address width of storage; memory holds 2**ADDR_W bytes.
STACK_TOP, 1024, SP reset value (empty stack); word-aligned, <= 2**ADDR_W.
STACK_LIMIT, 768, lowest legal SP; word-aligned, < STACK_TOP.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block accepts a request this cycle.
req_op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 reserved (treated as NOP).
req_size  in  2  LOAD/STORE size: 00 byte, 01 half, 10 word, 11 illegal.
req_signed  in  1  LOAD sign-extend when 1, zero-extend when 0.
req_addr  in  32  byte address for LOAD/STORE.
req_wdata  in  32  STORE/PUSH data (low bytes used for sub-word stores).
req_pc  in  32  return address pushed by CALL.
clear_fault  in  1  leave FAULT state.
rsp_valid  out  1  one-cycle pulse: response for the accepted request.
rsp_rdata  out  32  LOAD/POP/RET data; 0 for other ops.
rsp_fault  out  1  accepted request faulted.
fault_code  out  3  0 none, 1 misaligned, 2 out of range, 3 stack overflow, 4 stack underflow, 5 illegal size.
sp_out  out  32  current SP (registered).

Behaviour:
- Reset (async, rst_n low): state RUN, SP=STACK_TOP, rsp_valid=0, rsp_rdata=0, rsp_fault=0, fault_code=0, sp_out=STACK_TOP. Memory array is not reset. Reset mid-operation drops any in-flight response.
- FSM states: RUN (req_ready=1) and FAULT (req_ready=0).
- Acceptance: request accepted on a rising edge when req_valid=1 and req_ready=1.
- Response timing: rsp_valid=1 in the cycle after acceptance, for exactly one cycle. Back-to-back requests give back-to-back responses; throughput is 1 per cycle.
- NOP/reserved op: rsp_valid=1, rsp_rdata=0, no side effects.
- LOAD/STORE legality checks, first match wins:
  - size=11 -> fault 5.
  - half with addr[0]=1, or word with addr[1:0]!=0 -> fault 1.
  - addr >= 2**ADDR_W -> fault 2.
- STORE: writes only the addressed lanes (1, 2 or 4 bytes from req_wdata[7:0] upward).
- LOAD: reads the bytes and sign- or zero-extends to 32 bits.
- PUSH/CALL:
  - If SP-4 < STACK_LIMIT -> fault 3.
  - Otherwise SP<=SP-4 and the word (req_wdata or req_pc) is written at the new SP.
- POP/RET:
  - If SP == STACK_TOP -> fault 4.
  - Otherwise rsp_rdata = word at SP, then SP<=SP+4.
  - RET is identical to POP; the control unit loads rsp_rdata into the PC.
- sp_out updates in the same edge as SP, so it is visible together with the response.
- Any fault:
  - No memory write and no SP change.
  - rsp_valid=1, rsp_fault=1, fault_code set, rsp_rdata=0.
  - FSM -> FAULT; fault_code is held until cleared.
- In FAULT: requests are ignored (req_ready=0). clear_fault=1 -> RUN on the next edge and fault_code <= 0; no request is accepted in that same cycle. clear_fault in RUN has no effect.
- rsp_fault deasserts with rsp_valid. Stack-region addresses are legal for LOAD/STORE (no protection).

Test Plan:
- Reset, then PUSH 0xDEADBEEF, PUSH 0x12345678 -> sp_out 1020 then 1016; POP -> rdata 0x12345678, sp 1020; POP -> 0xDEADBEEF, sp 1024.
- STORE word 0x80FF7F01 @0x10; LOAD byte unsigned @0x12 -> 0x000000FF; byte signed @0x13 -> 0xFFFFFF80; half signed @0x10 -> 0x00007F01.
- STORE byte 0xAA @0x21 over word 0x11223344 @0x20 -> LOAD word @0x20 -> 0x1122AA44.
- POP at SP=1024 -> rsp_fault=1, code 4, req_ready=0, sp_out stays 1024; clear_fault with req_valid high -> request not accepted, RUN next cycle, code 0.
- 64 PUSHes -> sp 768; 65th -> code 3, sp 768 unchanged; CALL pc=0x40 after one POP -> RET returns 0x40.
- LOAD word @0x02 -> code 1; LOAD @0x400 -> code 2; size=11 -> code 5; each with no memory or SP change; rst_n pulsed mid-stream -> rsp_valid 0, sp 1024.

Source files
------------

// File: rtl/stack_data_mem_if.sv
// Request/response bus of the MEM-stage data memory and hardware stack.
// The master issues decoded operations; the slave answers one cycle later.
interface stack_data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        clear_fault;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [2:0]  fault_code;
  logic [31:0] sp_out;

  modport master (
    output req_valid, req_op, req_size, req_signed, req_addr, req_wdata, req_pc, clear_fault,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, fault_code, sp_out
  );

  modport slave (
    input  req_valid, req_op, req_size, req_signed, req_addr, req_wdata, req_pc, clear_fault,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, fault_code, sp_out
  );
endinterface

// File: rtl/stack_data_mem.sv
// Byte-addressed little-endian data memory with a bounds-checked downward stack,
// registered single-cycle response and a sticky FAULT state.
module stack_data_mem #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned STACK_TOP   = 1024,
  parameter int unsigned STACK_LIMIT = 768
) (
  input logic             clk,
  input logic             rst_n,
  stack_data_mem_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {RUN, FAULT} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_LOAD, OP_STORE, OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_RSVD
  } op_e;
  typedef enum logic [2:0] {
    F_NONE, F_MISALIGN, F_RANGE, F_OVERFLOW, F_UNDERFLOW, F_SIZE
  } fault_e;

  logic [7:0]        mem [DEPTH];
  state_e            state, state_nxt;
  fault_e            fault_c, fault_q;
  logic [31:0]       sp, sp_nxt, sp_dec, sp_inc;
  logic [31:0]       rd_data, wr_data;
  logic [ADDR_W-1:0] wr_addr, ld_addr, pop_addr;
  logic [3:0]        wr_lanes, mem_we;
  logic [7:0]        ld_b  [4];
  logic [7:0]        pop_b [4];
  logic              accept;
  op_e               op;

  assign op       = op_e'(bus.req_op);
  assign accept   = bus.req_valid & bus.req_ready;
  assign sp_dec   = sp - 32'd4;
  assign sp_inc   = sp + 32'd4;
  assign ld_addr  = ADDR_W'(bus.req_addr);
  assign pop_addr = ADDR_W'(sp);
  // Writes are also gated by rst_n since the array itself has no reset.
  assign mem_we   = wr_lanes & {4{accept & rst_n & (fault_c == F_NONE)}};

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      ld_b[i]  = mem[ld_addr + ADDR_W'(i)];
      pop_b[i] = mem[pop_addr + ADDR_W'(i)];
    end
  end

  always_comb begin
    fault_c  = F_NONE;
    sp_nxt   = sp;
    rd_data  = '0;
    wr_lanes = '0;
    wr_addr  = ld_addr;
    wr_data  = bus.req_wdata;
    case (op)
      OP_LOAD, OP_STORE: begin
        if (bus.req_size == 2'b11)
          fault_c = F_SIZE;
        else if ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
          fault_c = F_MISALIGN;
        else if ((bus.req_addr >> ADDR_W) != '0)
          fault_c = F_RANGE;
        else if (op == OP_STORE)
          wr_lanes = (bus.req_size == 2'b00) ? 4'b0001 :
                     (bus.req_size == 2'b01) ? 4'b0011 : 4'b1111;
        else begin
          case (bus.req_size)
            2'b00:   rd_data = {{24{bus.req_signed & ld_b[0][7]}}, ld_b[0]};
            2'b01:   rd_data = {{16{bus.req_signed & ld_b[1][7]}}, ld_b[1], ld_b[0]};
            default: rd_data = {ld_b[3], ld_b[2], ld_b[1], ld_b[0]};
          endcase
        end
      end
      OP_PUSH, OP_CALL: begin
        // Compare against LIMIT+4 so a small LIMIT cannot wrap SP-4.
        if (sp < 32'(STACK_LIMIT + 4))
          fault_c = F_OVERFLOW;
        else begin
          sp_nxt   = sp_dec;
          wr_addr  = ADDR_W'(sp_dec);
          wr_data  = (op == OP_CALL) ? bus.req_pc : bus.req_wdata;
          wr_lanes = 4'b1111;
        end
      end
      OP_POP, OP_RET: begin
        if (sp == 32'(STACK_TOP))
          fault_c = F_UNDERFLOW;
        else begin
          rd_data = {pop_b[3], pop_b[2], pop_b[1], pop_b[0]};
          sp_nxt  = sp_inc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = (state == RUN);
    case (state)
      RUN:     if (accept && fault_c != F_NONE) state_nxt = FAULT;
      FAULT:   if (bus.clear_fault) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp            <= 32'(STACK_TOP);
      fault_q       <= F_NONE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_fault <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_fault <= accept && (fault_c != F_NONE);
      bus.rsp_rdata <= (accept && fault_c == F_NONE) ? rd_data : '0;
      if (accept && fault_c == F_NONE)
        sp <= sp_nxt;
      if (accept && fault_c != F_NONE)
        fault_q <= fault_c;
      else if (state == FAULT && bus.clear_fault)
        fault_q <= F_NONE;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++)
      if (mem_we[i]) mem[wr_addr + ADDR_W'(i)] <= wr_data[8*i +: 8];
  end

  assign bus.fault_code = fault_q;
  assign bus.sp_out     = sp;
endmodule

// File: tb/tb_stack_data_mem.sv
// Directed self-checking bench for stack_data_mem: stack, sized loads/stores,
// fault handling, back-to-back throughput and asynchronous reset.
module tb_stack_data_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  stack_data_mem_if bus ();

  stack_data_mem #(.ADDR_W(10), .STACK_TOP(1024), .STACK_LIMIT(768)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Drives one request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_pc = pc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_op = 3'd0;
  endtask

  task automatic clear();
    bus.clear_fault = 1'b1;
    @(posedge clk); #1;
    bus.clear_fault = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.sp_out !== 32'd1024) begin n_err++; $display("FAIL reset_sp got %0d want 1024", bus.sp_out); end
    n_cmp++; if (bus.fault_code !== 3'd0) begin n_err++; $display("FAIL reset_code got %0d want 0", bus.fault_code); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", bus.rsp_rdata); end
  endtask

  task automatic test_push_pop();
    issue(3'd3, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0);
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL push1_valid got %b want 1", bus.rsp_valid); end
    n_cmp++; if (bus.sp_out !== 32'd1020) begin n_err++; $display("FAIL push1_sp got %0d want 1020", bus.sp_out); end
    issue(3'd3, 2'b10, 1'b0, 32'h0, 32'h12345678, 32'h0);
    n_cmp++; if (bus.sp_out !== 32'd1016) begin n_err++; $display("FAIL push2_sp got %0d want 1016", bus.sp_out); end
    issue(3'd4, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'h12345678) begin n_err++; $display("FAIL pop1_data got %h want 12345678", bus.rsp_rdata); end
    n_cmp++; if (bus.sp_out !== 32'd1020) begin n_err++; $display("FAIL pop1_sp got %0d want 1020", bus.sp_out); end
    issue(3'd4, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL pop2_data got %h want deadbeef", bus.rsp_rdata); end
    n_cmp++; if (bus.sp_out !== 32'd1024) begin n_err++; $display("FAIL pop2_sp got %0d want 1024", bus.sp_out); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL pulse_len got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_load_store();
    issue(3'd2, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_fault !== 1'b0) begin n_err++; $display("FAIL store_rsp got %h/%b want 0/0", bus.rsp_rdata, bus.rsp_fault); end
    issue(3'd1, 2'b00, 1'b0, 32'h12, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'h000000FF) begin n_err++; $display("FAIL lbu got %h want 000000ff", bus.rsp_rdata); end
    issue(3'd1, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb got %h want ffffff80", bus.rsp_rdata); end
    issue(3'd1, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'h00007F01) begin n_err++; $display("FAIL lh got %h want 00007f01", bus.rsp_rdata); end
    issue(3'd1, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'hFFFF80FF) begin n_err++; $display("FAIL lh_neg got %h want ffff80ff", bus.rsp_rdata); end
    issue(3'd1, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'h000080FF) begin n_err++; $display("FAIL lhu got %h want 000080ff", bus.rsp_rdata); end
    issue(3'd2, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0);
    issue(3'd2, 2'b00, 1'b0, 32'h21, 32'h5566_77AA, 32'h0);
    issue(3'd1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'h1122AA44) begin n_err++; $display("FAIL sb_lane got %h want 1122aa44", bus.rsp_rdata); end
    issue(3'd2, 2'b01, 1'b0, 32'h22, 32'hFFFF_BEEF, 32'h0);
    issue(3'd1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'hBEEFAA44) begin n_err++; $display("FAIL sh_lane got %h want beefaa44", bus.rsp_rdata); end
    issue(3'd1, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_fault !== 1'b0) begin n_err++; $display("FAIL last_word_legal got %b want 0", bus.rsp_fault); end
  endtask

  task automatic test_nop();
    issue(3'd0, 2'b10, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL nop got %b/%h want 1/0", bus.rsp_valid, bus.rsp_rdata); end
    issue(3'd7, 2'b10, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_fault !== 1'b0 || bus.sp_out !== 32'd1024) begin n_err++; $display("FAIL rsvd got v%b f%b sp%0d want 1/0/1024", bus.rsp_valid, bus.rsp_fault, bus.sp_out); end
    issue(3'd1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'h80FF7F01) begin n_err++; $display("FAIL nop_nowrite got %h want 80ff7f01", bus.rsp_rdata); end
  endtask

  task automatic test_underflow();
    issue(3'd4, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_fault !== 1'b1) begin n_err++; $display("FAIL uf_rsp got v%b f%b want 1/1", bus.rsp_valid, bus.rsp_fault); end
    n_cmp++; if (bus.fault_code !== 3'd4) begin n_err++; $display("FAIL uf_code got %0d want 4", bus.fault_code); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL uf_ready got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.sp_out !== 32'd1024 || bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL uf_sp got %0d/%h want 1024/0", bus.sp_out, bus.rsp_rdata); end
    issue(3'd3, 2'b10, 1'b0, 32'h0, 32'h55, 32'h0);
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_fault !== 1'b0 || bus.sp_out !== 32'd1024) begin n_err++; $display("FAIL fault_ignore got v%b f%b sp%0d want 0/0/1024", bus.rsp_valid, bus.rsp_fault, bus.sp_out); end
    n_cmp++; if (bus.fault_code !== 3'd4) begin n_err++; $display("FAIL code_held got %0d want 4", bus.fault_code); end
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_wdata = 32'h66; bus.clear_fault = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.clear_fault = 1'b0;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.sp_out !== 32'd1024) begin n_err++; $display("FAIL clear_noaccept got v%b sp%0d want 0/1024", bus.rsp_valid, bus.sp_out); end
    n_cmp++; if (bus.fault_code !== 3'd0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL clear_run got code%0d rdy%b want 0/1", bus.fault_code, bus.req_ready); end
    clear();
    n_cmp++; if (bus.fault_code !== 3'd0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL clear_in_run got code%0d rdy%b v%b want 0/1/0", bus.fault_code, bus.req_ready, bus.rsp_valid); end
  endtask

  task automatic test_stack_bounds();
    for (int i = 0; i < 64; i++) issue(3'd3, 2'b10, 1'b0, 32'h0, 32'(i + 100), 32'h0);
    n_cmp++; if (bus.sp_out !== 32'd768 || bus.rsp_fault !== 1'b0) begin n_err++; $display("FAIL fill_sp got %0d f%b want 768/0", bus.sp_out, bus.rsp_fault); end
    issue(3'd3, 2'b10, 1'b0, 32'h0, 32'hBAD0BAD0, 32'h0);
    n_cmp++; if (bus.fault_code !== 3'd3 || bus.rsp_fault !== 1'b1) begin n_err++; $display("FAIL of_code got %0d f%b want 3/1", bus.fault_code, bus.rsp_fault); end
    n_cmp++; if (bus.sp_out !== 32'd768) begin n_err++; $display("FAIL of_sp got %0d want 768", bus.sp_out); end
    clear();
    issue(3'd4, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'd163 || bus.sp_out !== 32'd772) begin n_err++; $display("FAIL of_pop got %0d sp%0d want 163/772", bus.rsp_rdata, bus.sp_out); end
    issue(3'd5, 2'b10, 1'b0, 32'h0, 32'h0, 32'h40);
    n_cmp++; if (bus.sp_out !== 32'd768 || bus.rsp_fault !== 1'b0) begin n_err++; $display("FAIL call got sp%0d f%b want 768/0", bus.sp_out, bus.rsp_fault); end
    issue(3'd6, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'h40 || bus.sp_out !== 32'd772) begin n_err++; $display("FAIL ret got %h sp%0d want 40/772", bus.rsp_rdata, bus.sp_out); end
    issue(3'd1, 2'b10, 1'b0, 32'd772, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'd162) begin n_err++; $display("FAIL stack_load got %0d want 162", bus.rsp_rdata); end
  endtask

  task automatic test_errors();
    do_reset();
    issue(3'd2, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0);
    issue(3'd1, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0);
    n_cmp++; if (bus.fault_code !== 3'd1 || bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL mis_word got %0d/%h want 1/0", bus.fault_code, bus.rsp_rdata); end
    clear();
    issue(3'd1, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0);
    n_cmp++; if (bus.fault_code !== 3'd2) begin n_err++; $display("FAIL range got %0d want 2", bus.fault_code); end
    clear();
    issue(3'd2, 2'b01, 1'b0, 32'h401, 32'h0, 32'h0);
    n_cmp++; if (bus.fault_code !== 3'd1) begin n_err++; $display("FAIL prio_mis got %0d want 1", bus.fault_code); end
    clear();
    issue(3'd2, 2'b11, 1'b0, 32'h1, 32'h0, 32'h0);
    n_cmp++; if (bus.fault_code !== 3'd5) begin n_err++; $display("FAIL size got %0d want 5", bus.fault_code); end
    clear();
    issue(3'd2, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0);
    n_cmp++; if (bus.fault_code !== 3'd1) begin n_err++; $display("FAIL mis_store got %0d want 1", bus.fault_code); end
    clear();
    issue(3'd1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (bus.rsp_rdata !== 32'hCAFEF00D || bus.sp_out !== 32'd1024) begin n_err++; $display("FAIL err_nowrite got %h sp%0d want cafef00d/1024", bus.rsp_rdata, bus.sp_out); end
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_wdata = 32'hA1A1A1A1;
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.sp_out !== 32'd1020) begin n_err++; $display("FAIL b2b_1 got v%b sp%0d want 1/1020", bus.rsp_valid, bus.sp_out); end
    bus.req_wdata = 32'hB2B2B2B2;
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.sp_out !== 32'd1016) begin n_err++; $display("FAIL b2b_2 got v%b sp%0d want 1/1016", bus.rsp_valid, bus.sp_out); end
    bus.req_op = 3'd4;
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hB2B2B2B2) begin n_err++; $display("FAIL b2b_3 got v%b %h want 1/b2b2b2b2", bus.rsp_valid, bus.rsp_rdata); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_rdata !== 32'hA1A1A1A1 || bus.sp_out !== 32'd1024) begin n_err++; $display("FAIL b2b_4 got %h sp%0d want a1a1a1a1/1024", bus.rsp_rdata, bus.sp_out); end
    bus.req_valid = 1'b0; bus.req_op = 3'd0;
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_midreset();
    issue(3'd3, 2'b10, 1'b0, 32'h0, 32'h77, 32'h0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.sp_out !== 32'd1024) begin n_err++; $display("FAIL midrst got v%b sp%0d want 0/1024", bus.rsp_valid, bus.sp_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.fault_code !== 3'd0) begin n_err++; $display("FAIL midrst_run got rdy%b code%0d want 1/0", bus.req_ready, bus.fault_code); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_pc = '0; bus.clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_push_pop();
    test_load_store();
    test_nop();
    test_underflow();
    test_stack_bounds();
    test_errors();
    test_back_to_back();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
